// File: rtl/sram_fifo_pkg.sv
// Shared defaults and grant encoding for the SRAM-backed FIFO front-end.
package sram_fifo_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int DEPTH  = 2 ** AW_DEF;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_WR   = 2'd1,
        G_RD   = 2'd2
    } grant_e;

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry skid buffer that holds SRAM read data until the consumer takes it.
module sram_fifo_obuf #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_append,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic [1:0]    o_cnt
);

    logic [DW-1:0] r_e0;
    logic [DW-1:0] r_e1;
    logic [1:0]    r_cnt;
    logic          w_pop;

    assign w_pop   = i_pop && (r_cnt != 2'd0);
    assign o_data  = r_e0;
    assign o_valid = (r_cnt != 2'd0);
    assign o_cnt   = r_cnt;

    // r_e0 is always the head; r_e1 only matters when two words are held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({i_append, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_e0 <= i_data;
                    else               r_e1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_e0 <= r_e1;
                        r_e1 <= i_data;
                    end else begin
                        r_e0 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO sequencer for a single-port SRAM: arbitrates writes against prefetch reads
// and hides the one-cycle read latency behind a two-entry output buffer.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    input  logic          pop_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] Addr,
    output logic          CS,
    output logic          WE,
    output logic          RD,
    output logic [DW-1:0] dataIn,
    input  logic [DW-1:0] dataOut
);

    localparam logic [AW:0]   C_FULL  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   C_CNT1  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] C_PTR1  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_sram_cnt;
    logic          r_rd_inflight;
    logic          r_last_grant;

    logic [1:0]    w_obuf_cnt;
    logic          w_pop_fire;
    logic [2:0]    w_slots;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_contend;
    logic [AW:0]   w_count;
    grant_e        w_grant;

    sram_fifo_obuf #(.DW(DW)) u_obuf (
        .i_clk    (Clk),
        .i_rst_n  (Rst_n),
        .i_append (r_rd_inflight),
        .i_data   (dataOut),
        .i_pop    (w_pop_fire),
        .o_data   (pop_data),
        .o_valid  (pop_valid),
        .o_cnt    (w_obuf_cnt)
    );

    assign w_pop_fire = pop_valid && pop_ready;
    assign w_slots    = {1'b0, w_obuf_cnt} + {2'b00, r_rd_inflight};

    // A read may only start if its word will have a buffer slot when it lands.
    assign w_wr_ok   = Rst_n && push_valid && (r_sram_cnt != C_FULL);
    assign w_rd_ok   = Rst_n && (r_sram_cnt != '0) && (w_slots < (3'd2 + {2'b00, w_pop_fire}));
    assign w_contend = w_wr_ok && w_rd_ok;

    // r_last_grant is 1 when the previous contended cycle went to the write side.
    always_comb begin
        w_grant = G_IDLE;
        if (w_contend)    w_grant = r_last_grant ? G_RD : G_WR;
        else if (w_wr_ok) w_grant = G_WR;
        else if (w_rd_ok) w_grant = G_RD;
    end

    always_comb begin
        CS         = 1'b0;
        WE         = 1'b0;
        RD         = 1'b0;
        Addr       = '0;
        dataIn     = '0;
        push_ready = 1'b0;
        case (w_grant)
            G_WR: begin
                CS         = 1'b1;
                WE         = 1'b1;
                Addr       = r_wr_ptr;
                dataIn     = push_data;
                push_ready = 1'b1;
            end
            G_RD: begin
                CS   = 1'b1;
                RD   = 1'b1;
                Addr = r_rd_ptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_sram_cnt    <= '0;
            r_rd_inflight <= 1'b0;
            r_last_grant  <= 1'b0;
        end else begin
            if (w_grant == G_WR) begin
                r_wr_ptr   <= r_wr_ptr + C_PTR1;
                r_sram_cnt <= r_sram_cnt + C_CNT1;
            end else if (w_grant == G_RD) begin
                r_rd_ptr   <= r_rd_ptr + C_PTR1;
                r_sram_cnt <= r_sram_cnt - C_CNT1;
            end
            r_rd_inflight <= (w_grant == G_RD);
            if (w_contend) r_last_grant <= (w_grant == G_WR);
        end
    end

    assign w_count = r_sram_cnt + {{AW{1'b0}}, r_rd_inflight} + {{(AW-1){1'b0}}, w_obuf_cnt};
    assign count   = w_count;
    assign full    = (r_sram_cnt == C_FULL);
    assign empty   = (w_count == '0);

endmodule
